td_stream_fifo: RTL and testbench

Parametrised successor FIFO for `TaggedDirection` traffic between ray-generation and traversal stages. It uses a valid/ready handshake on both sides and first-word-fall-through output. It adds occupancy reporting, a programmable almost-full threshold, synchronous flush, and a selectable full-policy: backpressure, or drop-newest with a sticky overflow flag and a drop counter. Storage is one simple-dual-port BRAM holding the packed struct.

---
 rtl/td_stream_fifo_pkg.sv | 25 ++
 rtl/td_sdp_ram.sv | 27 ++
 rtl/td_stream_fifo.sv | 138 +++++++++++++
 tb/tb_td_stream_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/td_stream_fifo_pkg.sv
// Shared types for TaggedDirection traffic between ray-generation and traversal.
// Component and tag widths come from the WIDTH/TAG_SIZE macros so every stage agrees.
`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

package td_stream_fifo_pkg;

  localparam int TD_BITS = 3*`WIDTH + `TAG_SIZE;

  typedef struct packed {
    logic [`WIDTH-1:0]    x;
    logic [`WIDTH-1:0]    y;
    logic [`WIDTH-1:0]    z;
    logic [`TAG_SIZE-1:0] tag;
  } TaggedDirection;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/td_sdp_ram.sv
// Simple-dual-port storage: one write port, one enable-gated registered read port.
// The read register holds its value while re_i is low, so it doubles as a skid slot.
module td_sdp_ram #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/td_stream_fifo.sv
// First-word-fall-through FIFO for TaggedDirection with occupancy, almost-full,
// flush and a selectable full-policy (backpressure or drop-newest with counters).
module td_stream_fifo
  import td_stream_fifo_pkg::*;
#(
  parameter int WIDTH        = `WIDTH,
  parameter int TAG_SIZE     = `TAG_SIZE,
  parameter int DEPTH        = 32,
  parameter int AFULL_LEVEL  = DEPTH - 4,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  TaggedDirection             dir_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output TaggedDirection             dir_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       clr_overflow,
  output logic [15:0]                drop_count
);

  localparam int DW = 3*WIDTH + TAG_SIZE;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, unread;
  logic          out_vld_q, out_vld_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] wr_data, ram_rdata;
  logic          ovf_q, ovf_d;
  logic [15:0]   drops_q, drops_d;
  logic          full, push, pop, drop, xfer, rd_en;

  assign wr_data = dir_in;

  assign full     = (count_q == FULL_CNT);
  assign in_ready = DROP_ON_FULL ? 1'b1 : !full;
  assign push     = in_valid && !full && !flush;
  assign pop      = out_vld_q && out_ready && !flush;
  assign drop     = DROP_ON_FULL && in_valid && full && !flush;

  // pend_q marks a RAM read result waiting in the RAM read register; it moves
  // into the output register once that register is empty or being popped.
  assign xfer   = pend_q && (!out_vld_q || pop);
  // count covers head and in-flight read, so the rest is still unread in RAM.
  // An entry written on this edge is not yet in count, so it is never read here.
  assign unread = count_q - CW'(out_vld_q) - CW'(pend_q);
  assign rd_en  = (unread != '0) && (!pend_q || xfer) && !flush;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    out_vld_d = out_vld_q;
    pend_d    = pend_q;
    dout_d    = dout_q;
    ovf_d     = ovf_q;
    drops_d   = drops_q;

    if (flush) begin
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      out_vld_d = 1'b0;
      pend_d    = 1'b0;
    end else begin
      if (push)  wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      if (xfer) begin
        dout_d    = ram_rdata;
        out_vld_d = 1'b1;
      end else if (pop) begin
        out_vld_d = 1'b0;
      end
      pend_d = rd_en || (pend_q && !xfer);
    end

    // A drop on the same edge as a clear restarts the count at one.
    if (drop) begin
      ovf_d   = 1'b1;
      drops_d = clr_overflow ? 16'd1 : sat_inc16(drops_q);
    end else if (clr_overflow) begin
      ovf_d   = 1'b0;
      drops_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      out_vld_q <= 1'b0;
      pend_q    <= 1'b0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      drops_q   <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
      pend_q    <= pend_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      drops_q   <= drops_d;
    end
  end

  td_sdp_ram #(.DATA_W(DW), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  assign dir_out     = dout_q;
  assign out_valid   = out_vld_q;
  assign count       = count_q;
  assign almost_full = (count_q >= AFULL_CNT);
  assign overflow    = ovf_q;
  assign drop_count  = drops_q;

endmodule

// File: tb/tb_td_stream_fifo.sv
// Scoreboard bench: one backpressure and one drop-mode FIFO driven in lockstep.
module tb_td_stream_fifo;
  import td_stream_fifo_pkg::*;

  logic clk, rst_n, flush, in_valid, out_ready, clr_overflow;
  TaggedDirection dir_in;
  logic in_ready0, out_valid0, almost_full0, overflow0;
  logic in_ready1, out_valid1, almost_full1, overflow1;
  TaggedDirection dir_out0, dir_out1;
  logic [5:0]  count0, count1;
  logic [15:0] drop_count0, drop_count1;

  int n_cmp = 0;
  int n_err = 0;
  TaggedDirection q[$];

  td_stream_fifo #(.DEPTH(32), .DROP_ON_FULL(1'b0)) dut0 (
    .clk(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .dir_in(dir_in), .out_valid(out_valid0), .out_ready(out_ready), .dir_out(dir_out0),
    .count(count0), .almost_full(almost_full0), .overflow(overflow0),
    .clr_overflow(clr_overflow), .drop_count(drop_count0));

  td_stream_fifo #(.DEPTH(32), .DROP_ON_FULL(1'b1)) dut1 (
    .clk(clk), .reset(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .dir_in(dir_in), .out_valid(out_valid1), .out_ready(out_ready), .dir_out(dir_out1),
    .count(count1), .almost_full(almost_full1), .overflow(overflow1),
    .clr_overflow(clr_overflow), .drop_count(drop_count1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic TaggedDirection mk(input int i);
    TaggedDirection r;
    r.x   = `WIDTH'(i);
    r.y   = `WIDTH'(i + 1000);
    r.z   = `WIDTH'(i ^ 32'h5a5a);
    r.tag = `TAG_SIZE'(i * 3);
    return r;
  endfunction

  // Book the handshakes of the current cycle, then advance one clock edge.
  task automatic tick();
    TaggedDirection e;
    if (flush) q.delete();
    else begin
      if (in_valid && in_ready0) q.push_back(dir_in);
      if (out_valid0 && out_ready) begin
        if (q.size() == 0) chk("sb_underflow", out_valid0, 0);
        else begin
          e = q.pop_front();
          chk("dout0", dir_out0, e);
          chk("dout1", dir_out1, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 200 && q.size() != 0; n++) tick();
    out_ready = 1'b0;
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    TaggedDirection d;
    int bubbles, cnt_bad;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
    dir_in = '0;
    @(posedge clk); #1;
    chk("rst_count", count0, 0);
    chk("rst_ovalid", out_valid0, 0);
    chk("rst_dout", dir_out0, 0);
    chk("rst_afull", almost_full0, 0);
    chk("rst_inready0", in_ready0, 1);
    chk("rst_inready1", in_ready1, 1);
    chk("rst_ovf1", overflow1, 0);
    chk("rst_drops1", drop_count1, 0);
    rst_n = 1'b1;
    tick();

    // Single entry: fall-through latency of two edges.
    d.x = 1; d.y = 2; d.z = 3; d.tag = 7;
    dir_in = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("one_count", count0, 1);
    chk("one_ov_k", out_valid0, 0);
    tick();
    chk("one_ov_k1", out_valid0, 0);
    tick();
    chk("one_ov_k2", out_valid0, 1);
    chk("one_dout", dir_out0, d);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_count_after", count0, 0);

    // Fill to capacity with the consumer stalled.
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dir_in = mk(i);
      tick();
      chk("fill_count0", count0, i + 1);
      chk("fill_count1", count1, i + 1);
      chk("fill_afull", almost_full0, (i + 1) >= 28);
    end
    chk("full_inready0", in_ready0, 0);
    chk("full_inready1", in_ready1, 1);
    dir_in = mk(99);
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b0;
    chk("hold_count0", count0, 32);
    chk("drop_count1", count1, 32);
    chk("drop_ovf1", overflow1, 1);
    chk("drop_cnt1", drop_count1, 3);
    chk("hold_ovf0", overflow0, 0);
    chk("hold_drops0", drop_count0, 0);
    clr_overflow = 1'b1;
    tick();
    chk("clr_ovf1", overflow1, 0);
    chk("clr_drops1", drop_count1, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; clr_overflow = 1'b0;
    chk("clrdrop_ovf1", overflow1, 1);
    chk("clrdrop_cnt1", drop_count1, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    drain();
    chk("fill_drained", count0, 0);

    // Streaming through pointer wrap.
    bubbles = 0; cnt_bad = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      dir_in = mk(100 + i);
      tick();
      if (i >= 2) begin
        if (!out_valid0) bubbles++;
        if (count0 != 3) cnt_bad++;
      end
    end
    in_valid = 1'b0;
    chk("stream_bubbles", bubbles, 0);
    chk("stream_count", cnt_bad, 0);
    drain();

    // Flush with ten entries queued and a transfer about to happen.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dir_in = mk(300 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("preflush_count", count0, 10);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_count0", count0, 0);
    chk("flush_count1", count1, 0);
    chk("flush_ov0", out_valid0, 0);
    chk("flush_ov1", out_valid1, 0);
    dir_in = mk(555); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("postflush_ov_k1", out_valid0, 0);
    tick();
    chk("postflush_ov_k2", out_valid0, 1);
    drain();

    // Asynchronous reset in the middle of a cycle, with drop-mode overflow set.
    in_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      dir_in = mk(700 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("prerst_ovf1", overflow1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count0", count0, 0);
    chk("arst_count1", count1, 0);
    chk("arst_ov0", out_valid0, 0);
    chk("arst_dout0", dir_out0, 0);
    chk("arst_afull0", almost_full0, 0);
    chk("arst_ovf1", overflow1, 0);
    chk("arst_drops1", drop_count1, 0);
    chk("arst_inready0", in_ready0, 1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    dir_in = mk(900); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("postrst_ov", out_valid0, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
